// File: rtl/fence_hazard_ctrl.sv
// Front-pipeline hazard scheduler: prioritises trap/MMU/branch/fence/load-use
// into hazard_signal and sequences fence drains followed by cache/TLB maintenance.
module fence_hazard_ctrl #(
  parameter int unsigned MIN_DRAIN = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned OUTST_W   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trap,
  input  logic               mmu_busy,
  input  logic               branch_taken,
  input  logic               fence_id,
  input  logic [1:0]         fence_kind,
  input  logic [4:0]         if_rs1,
  input  logic [4:0]         if_rs2,
  input  logic [4:0]         id_rd,
  input  logic               id_is_load,
  input  logic [OUTST_W-1:0] mem_outstanding,
  output logic [3:0]         hazard_signal,
  output logic               fence_busy,
  output logic               icache_inv,
  output logic               tlb_flush,
  output logic               fence_timeout,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        fence_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef enum logic [3:0] {
    HZ_NONE        = 4'd0,
    HZ_STALL_EARLY = 4'd1,
    HZ_STALL_MMU   = 4'd2,
    HZ_FLUSH_EARLY = 4'd3,
    HZ_FLUSH_ALL   = 4'd4
  } hazard_t;

  localparam logic [3:0] MIN_DRAIN_L = 4'(MIN_DRAIN);
  localparam logic [7:0] TIMEOUT_L   = 8'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_drain_cnt;
  logic [3:0]  w_drain_nxt;
  logic [3:0]  w_drain_dec;
  logic [7:0]  r_to_cnt;
  logic [7:0]  w_to_nxt;
  logic [7:0]  w_to_inc;
  logic [1:0]  r_kind;
  logic [1:0]  w_kind_nxt;
  logic        w_to_hit;
  logic        r_fence_timeout;
  logic [31:0] r_stall_cycles;
  logic [15:0] r_fence_count;
  logic        w_load_use;
  hazard_t     w_hazard;

  assign w_load_use  = id_is_load && (id_rd != '0) &&
                       ((id_rd == if_rs1) || (id_rd == if_rs2));
  assign w_drain_dec = (r_drain_cnt == '0) ? '0 : r_drain_cnt - 4'd1;
  assign w_to_inc    = r_to_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Exit tests use the post-decrement/post-increment values so that DRAIN
  // lasts exactly MIN_DRAIN cycles and a timeout fires on the TIMEOUT-th cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    w_to_nxt    = r_to_cnt;
    w_kind_nxt  = r_kind;
    w_to_hit    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (fence_id && !trap && !branch_taken && !mmu_busy) begin
          w_state_nxt = S_DRAIN;
          w_drain_nxt = MIN_DRAIN_L;
          w_to_nxt    = '0;
          w_kind_nxt  = fence_kind;
        end
      end
      S_DRAIN: begin
        if (trap || branch_taken) begin
          w_state_nxt = S_IDLE;
        end else if (!mmu_busy) begin
          w_drain_nxt = w_drain_dec;
          w_to_nxt    = w_to_inc;
          if ((w_drain_dec == '0) && (mem_outstanding == '0)) begin
            w_state_nxt = S_DONE;
          end else if (w_to_inc == TIMEOUT_L) begin
            w_state_nxt = S_DONE;
            w_to_hit    = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_hazard   = HZ_NONE;
    fence_busy = (r_state == S_DRAIN);
    icache_inv = (r_state == S_DONE) && (r_kind == 2'd1);
    tlb_flush  = (r_state == S_DONE) && (r_kind == 2'd2);
    if (trap) begin
      w_hazard = HZ_FLUSH_ALL;
    end else if (mmu_busy) begin
      w_hazard = HZ_STALL_MMU;
    end else if (branch_taken) begin
      w_hazard = HZ_FLUSH_EARLY;
    end else if ((r_state == S_DRAIN) || ((r_state == S_IDLE) && fence_id)) begin
      w_hazard = HZ_STALL_EARLY;
    end else if (w_load_use) begin
      w_hazard = HZ_STALL_EARLY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_cnt     <= '0;
      r_to_cnt        <= '0;
      r_kind          <= '0;
      r_fence_timeout <= 1'b0;
      r_stall_cycles  <= '0;
      r_fence_count   <= '0;
    end else begin
      r_drain_cnt <= w_drain_nxt;
      r_to_cnt    <= w_to_nxt;
      r_kind      <= w_kind_nxt;
      if (w_to_hit) begin
        r_fence_timeout <= 1'b1;
      end
      if ((w_hazard == HZ_STALL_EARLY) || (w_hazard == HZ_STALL_MMU)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (r_state == S_DONE) begin
        r_fence_count <= r_fence_count + 16'd1;
      end
    end
  end

  assign hazard_signal = w_hazard;
  assign fence_timeout = r_fence_timeout;
  assign stall_cycles  = r_stall_cycles;
  assign fence_count   = r_fence_count;

endmodule

// File: tb/tb_fence_hazard_ctrl.sv
// Bench for fence_hazard_ctrl: cycle-level reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fence_hazard_ctrl;

  localparam int TB_MIN = 4;
  localparam int TB_TO  = 20;

  logic        clk;
  logic        rst_n;
  logic        trap;
  logic        mmu_busy;
  logic        branch_taken;
  logic        fence_id;
  logic [1:0]  fence_kind;
  logic [4:0]  if_rs1;
  logic [4:0]  if_rs2;
  logic [4:0]  id_rd;
  logic        id_is_load;
  logic [2:0]  mem_outstanding;
  logic [3:0]  hazard_signal;
  logic        fence_busy;
  logic        icache_inv;
  logic        tlb_flush;
  logic        fence_timeout;
  logic [31:0] stall_cycles;
  logic [15:0] fence_count;

  fence_hazard_ctrl #(
    .MIN_DRAIN(TB_MIN),
    .TIMEOUT  (TB_TO),
    .OUTST_W  (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .trap           (trap),
    .mmu_busy       (mmu_busy),
    .branch_taken   (branch_taken),
    .fence_id       (fence_id),
    .fence_kind     (fence_kind),
    .if_rs1         (if_rs1),
    .if_rs2         (if_rs2),
    .id_rd          (id_rd),
    .id_is_load     (id_is_load),
    .mem_outstanding(mem_outstanding),
    .hazard_signal  (hazard_signal),
    .fence_busy     (fence_busy),
    .icache_inv     (icache_inv),
    .tlb_flush      (tlb_flush),
    .fence_timeout  (fence_timeout),
    .stall_cycles   (stall_cycles),
    .fence_count    (fence_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=no fence, 1=draining, 2=maintenance cycle.
  int          m_phase;
  int          m_served;
  int          m_kind;
  bit          m_timeout;
  int unsigned m_stalls;
  int unsigned m_fences;

  function automatic int exp_hazard();
    bit lu;
    lu = id_is_load && (id_rd != 0) && (id_rd == if_rs1 || id_rd == if_rs2);
    if (trap) return 4;
    if (mmu_busy) return 2;
    if (branch_taken) return 3;
    if (m_phase == 1 || (m_phase == 0 && fence_id)) return 1;
    if (lu) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int h;
    if (!rst_n) begin
      m_phase = 0; m_served = 0; m_kind = 0;
      m_timeout = 0; m_stalls = 0; m_fences = 0;
    end else begin
      h = exp_hazard();
      if (h == 1 || h == 2) m_stalls = m_stalls + 1;
      case (m_phase)
        0: if (fence_id && !trap && !branch_taken && !mmu_busy) begin
             m_phase = 1; m_served = 0; m_kind = int'(fence_kind);
           end
        1: if (trap || branch_taken) m_phase = 0;
           else if (!mmu_busy) begin
             m_served++;
             if (m_served >= TB_MIN && mem_outstanding == 0) m_phase = 2;
             else if (m_served == TB_TO) begin m_phase = 2; m_timeout = 1; end
           end
        default: begin m_fences = (m_fences + 1) & 32'hFFFF; m_phase = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("hazard_signal", 64'(hazard_signal), 64'(exp_hazard()));
    chk("fence_busy", 64'(fence_busy), 64'(m_phase == 1));
    chk("icache_inv", 64'(icache_inv), 64'(m_phase == 2 && m_kind == 1));
    chk("tlb_flush", 64'(tlb_flush), 64'(m_phase == 2 && m_kind == 2));
    chk("fence_timeout", 64'(fence_timeout), 64'(m_timeout));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    chk("fence_count", 64'(fence_count), 64'(m_fences));
  end

  int busy_run;
  int icache_cnt;
  int tlb_cnt;
  always @(negedge clk) begin
    if (fence_busy) busy_run++;
    if (icache_inv) icache_cnt++;
    if (tlb_flush)  tlb_cnt++;
  end

  task automatic clear_mon();
    busy_run = 0; icache_cnt = 0; tlb_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Steps until the model enters its maintenance cycle, then finishes that cycle.
  task automatic wait_done(input int max, input bit keep_id, input bit trap_at_done);
    bit done = 0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (m_phase == 2) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_done bound of %0d cycles expired", max);
    end else begin
      if (!keep_id) fence_id = 1'b0;
      if (trap_at_done) trap = 1'b1;
      tick();
      trap = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; trap = 1'b0; mmu_busy = 1'b0; branch_taken = 1'b0;
    fence_id = 1'b0; fence_kind = 2'd0; if_rs1 = '0; if_rs2 = '0;
    id_rd = '0; id_is_load = 1'b0; mem_outstanding = '0;
    clear_mon();
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_hazard", 64'(hazard_signal), 64'd0);
    chk("rst_stalls", 64'(stall_cycles), 64'd0);
    chk("rst_fences", 64'(fence_count), 64'd0);
    chk("rst_timeout", 64'(fence_timeout), 64'd0);
    tick();

    // FENCE.I, nothing outstanding: 1 IDLE + 4 DRAIN stall cycles.
    clear_mon();
    fence_kind = 2'd1; fence_id = 1'b1;
    wait_done(20, 0, 0);
    chk("s1_stalls", 64'(stall_cycles), 64'd5);
    chk("s1_fences", 64'(fence_count), 64'd1);
    chk("s1_drain_len", 64'(busy_run), 64'd4);
    chk("s1_icache_pulses", 64'(icache_cnt), 64'd1);

    // SFENCE.VMA with mem_outstanding=3 for 10 cycles.
    clear_mon();
    fence_kind = 2'd2; fence_id = 1'b1; mem_outstanding = 3'd3;
    repeat (10) tick();
    mem_outstanding = '0;
    wait_done(20, 0, 0);
    chk("s2_drain_len", 64'(busy_run), 64'd10);
    chk("s2_tlb_pulses", 64'(tlb_cnt), 64'd1);
    chk("s2_icache_pulses", 64'(icache_cnt), 64'd0);
    chk("s2_timeout", 64'(fence_timeout), 64'd0);

    // Stuck outstanding op -> timeout, then a back-to-back fence.
    clear_mon();
    fence_kind = 2'd0; fence_id = 1'b1; mem_outstanding = 3'd1;
    wait_done(40, 1, 0);
    chk("s3_drain_len", 64'(busy_run), 64'd20);
    chk("s3_timeout", 64'(fence_timeout), 64'd1);
    chk("s3_fences", 64'(fence_count), 64'd3);
    clear_mon();
    mem_outstanding = '0; fence_kind = 2'd3;
    wait_done(20, 0, 0);
    chk("s3b_drain_len", 64'(busy_run), 64'd4);
    chk("s3b_timeout_sticky", 64'(fence_timeout), 64'd1);
    chk("s3b_fences", 64'(fence_count), 64'd4);

    // Priority ladder.
    trap = 1'b1; mmu_busy = 1'b1; id_is_load = 1'b1; id_rd = 5'd5; if_rs2 = 5'd5;
    @(negedge clk); chk("prio_trap", 64'(hazard_signal), 64'd4); tick();
    trap = 1'b0;
    @(negedge clk); chk("prio_mmu", 64'(hazard_signal), 64'd2); tick();
    mmu_busy = 1'b0;
    @(negedge clk); chk("prio_loaduse", 64'(hazard_signal), 64'd1); tick();
    id_rd = 5'd0;
    @(negedge clk); chk("prio_rd0", 64'(hazard_signal), 64'd0); tick();
    id_is_load = 1'b0; if_rs2 = '0;

    // Branch in DRAIN cycle 2 aborts the fence.
    clear_mon();
    fence_kind = 2'd1; fence_id = 1'b1;
    tick(); tick();
    branch_taken = 1'b1; fence_id = 1'b0;
    @(negedge clk); chk("s5_branch_hazard", 64'(hazard_signal), 64'd3);
    tick();
    branch_taken = 1'b0;
    repeat (3) tick();
    chk("s5_busy", 64'(fence_busy), 64'd0);
    chk("s5_fences", 64'(fence_count), 64'd4);
    chk("s5_icache_pulses", 64'(icache_cnt), 64'd0);

    // MMU busy for 3 cycles mid-DRAIN extends it by 3.
    clear_mon();
    fence_kind = 2'd2; fence_id = 1'b1;
    tick(); tick();
    mmu_busy = 1'b1;
    repeat (3) tick();
    mmu_busy = 1'b0;
    wait_done(20, 0, 0);
    chk("s6_drain_len", 64'(busy_run), 64'd7);
    chk("s6_tlb_pulses", 64'(tlb_cnt), 64'd1);
    chk("s6_fences", 64'(fence_count), 64'd5);

    // Trap during the maintenance cycle still pulses and counts.
    clear_mon();
    fence_kind = 2'd1; fence_id = 1'b1;
    wait_done(20, 0, 1);
    chk("s7_icache_pulses", 64'(icache_cnt), 64'd1);
    chk("s7_fences", 64'(fence_count), 64'd6);

    // Reset mid-DRAIN aborts without a pulse and clears the sticky flag.
    clear_mon();
    fence_kind = 2'd1; fence_id = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    fence_id = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("s8_icache_pulses", 64'(icache_cnt), 64'd0);
    chk("s8_fences", 64'(fence_count), 64'd0);
    chk("s8_timeout", 64'(fence_timeout), 64'd0);
    chk("s8_busy", 64'(fence_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit expired");
    $fatal(1);
  end

endmodule
